mod_2n1_reducer: RTL and testbench



---
 rtl/mod_2n1_reducer.sv | 135 +++++++++++++
 tb/tb_mod_2n1_reducer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mod_2n1_reducer.sv
// mod_2n1_reducer: two-stage valid/ready residue stage behind the Booth multiplier.
// It returns the full signed 2N-bit product, the product mod 2^N+1, or the product
// mod 2^N, selected per transaction by in_mode.
// Optional macro MOD_DIMINISHED_ONE_EN: when defined, the mod 2^N+1 result is
// emitted in diminished-one form.
module mod_2n1_reducer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_product,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_result,
    output logic [1:0]     out_mode
);

    // Difference L - H spans [-(2^(N-1)-1), 2^N-1+2^(N-1)], so N+2 signed bits hold it exactly.
    localparam int DW = N + 2;
    localparam logic signed [DW-1:0] MODULUS = DW'((1 << N) + 1);

    // One conditional add/subtract of M brings the difference into [0, 2^N].
    function automatic logic [DW-1:0] mod_correct(input logic signed [DW-1:0] d);
        logic signed [DW-1:0] r;
        if (d[DW-1]) begin
            r = d + MODULUS;
        end else if (d >= MODULUS) begin
            r = d - MODULUS;
        end else begin
            r = d;
        end
        return r;
    endfunction

`ifdef MOD_DIMINISHED_ONE_EN
    // Diminished-one code: zero maps to the flag bit 2^N, any other r maps to r-1.
    function automatic logic [DW-1:0] to_dim_one(input logic [DW-1:0] r);
        logic [DW-1:0] zero_code;
        zero_code    = '0;
        zero_code[N] = 1'b1;
        if (r == '0) begin
            return zero_code;
        end
        return r - DW'(1);
    endfunction
`endif

    logic                 ld_p1;
    logic                 ld_p2;

    logic signed [DW-1:0] low_ext;
    logic signed [DW-1:0] high_ext;
    logic signed [DW-1:0] diff_d;

    logic                 vld_p1_q;
    logic signed [DW-1:0] diff_p1_q;
    logic [N-1:0]         low_p1_q;
    logic [2*N-1:0]       prod_p1_q;
    logic [1:0]           mode_p1_q;

    logic [DW-1:0]        residue_d;
    logic [2*N-1:0]       result_d;

    logic                 vld_p2_q;
    logic [2*N-1:0]       result_p2_q;
    logic [1:0]           mode_p2_q;

    // Stage 2 advances when empty or draining; stage 1 advances when empty or stage 2 takes it.
    assign ld_p2    = !vld_p2_q || out_ready;
    assign ld_p1    = !vld_p1_q || ld_p2;
    assign in_ready = rst_n && ld_p1;

    // 2^N == -1 (mod M): fold the high half (signed) out of the low half (unsigned).
    assign low_ext  = {2'b00, in_product[N-1:0]};
    assign high_ext = {{2{in_product[2*N-1]}}, in_product[2*N-1:N]};
    assign diff_d   = low_ext - high_ext;

    // ---- stage 0 -> stage 1 boundary ----
    // Stage 1 occupancy, cleared by reset so in-flight entries are discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
        end else if (ld_p1) begin
            vld_p1_q <= in_valid;
        end
    end

    // Stage 1 payload: exact difference, low half, full product and mode.
    always_ff @(posedge clk) begin
        if (ld_p1 && in_valid) begin
            diff_p1_q <= diff_d;
            low_p1_q  <= in_product[N-1:0];
            prod_p1_q <= in_product;
            mode_p1_q <= in_mode;
        end
    end

    // ---- stage 1 -> stage 2 boundary ----
    // Select the result for the carried mode; residues are zero-extended to 2N bits.
    always_comb begin
        residue_d = mod_correct(diff_p1_q);
`ifdef MOD_DIMINISHED_ONE_EN
        residue_d = to_dim_one(residue_d);
`endif
        result_d = prod_p1_q;
        case (mode_p1_q)
            2'b01:   result_d = {{(2*N-DW){1'b0}}, residue_d};
            2'b10:   result_d = {{N{1'b0}}, low_p1_q};
            default: result_d = prod_p1_q;
        endcase
    end

    // Output register: holds result and mode stable while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2_q    <= 1'b0;
            result_p2_q <= '0;
            mode_p2_q   <= '0;
        end else if (ld_p2) begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                result_p2_q <= result_d;
                mode_p2_q   <= mode_p1_q;
            end
        end
    end

    assign out_valid  = vld_p2_q;
    assign out_result = result_p2_q;
    assign out_mode   = mode_p2_q;

endmodule

// File: tb/tb_mod_2n1_reducer.sv
// Directed bench for mod_2n1_reducer with N=8 (M=257).
// Expected mod-257 values follow MOD_DIMINISHED_ONE_EN when the bench is built with it.
module tb_mod_2n1_reducer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_product;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_mode;

    int total = 0;
    int bad   = 0;

`ifdef MOD_DIMINISHED_ONE_EN
    localparam logic [15:0] E_2710 = 16'd233;
    localparam logic [15:0] E_4000 = 16'd192;
    localparam logic [15:0] E_FFF1 = 16'd241;
    localparam logic [15:0] E_FDFF = 16'd0;
    localparam logic [15:0] E_FFFF = 16'd255;
    localparam logic [15:0] E_FEFF = 16'h0100;
    localparam logic [15:0] E_0000 = 16'h0100;
`else
    localparam logic [15:0] E_2710 = 16'd234;
    localparam logic [15:0] E_4000 = 16'd193;
    localparam logic [15:0] E_FFF1 = 16'd242;
    localparam logic [15:0] E_FDFF = 16'd1;
    localparam logic [15:0] E_FFFF = 16'd256;
    localparam logic [15:0] E_FEFF = 16'd0;
    localparam logic [15:0] E_0000 = 16'd0;
`endif

    mod_2n1_reducer #(.N(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_mode   (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single isolated transfer: one cycle in stage 1, then visible on the output.
    task automatic run_one(input string tag, input logic [15:0] p, input logic [1:0] m,
                           input logic [15:0] e);
        @(negedge clk);
        in_valid   = 1'b1;
        in_product = p;
        in_mode    = m;
        #1;
        check_b({tag, "_ready"}, in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_b({tag, "_notyet"}, out_valid, 1'b0);
        @(negedge clk);
        check_b({tag, "_valid"}, out_valid, 1'b1);
        check_w({tag, "_result"}, out_result, e);
        check_w({tag, "_mode"}, 16'(out_mode), 16'(m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] sp [5];
        logic [15:0] se [5];
        int          ni;
        int          no;
        logic        acc;

        sp = '{16'h2710, 16'h4000, 16'hFFF1, 16'hFDFF, 16'hFFFF};
        se = '{E_2710, E_4000, E_FFF1, E_FDFF, E_FFFF};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = 16'h0000;
        in_mode    = 2'b00;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_b("rst_out_valid", out_valid, 1'b0);
        check_w("rst_out_result", out_result, 16'h0000);
        check_w("rst_out_mode", 16'(out_mode), 16'h0000);
        check_b("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        check_b("post_rst_in_ready", in_ready, 1'b1);

        run_one("m01_10000", 16'h2710, 2'b01, E_2710);
        run_one("m01_16384", 16'h4000, 2'b01, E_4000);
        run_one("m01_neg15", 16'hFFF1, 2'b01, E_FFF1);
        run_one("m01_neg513", 16'hFDFF, 2'b01, E_FDFF);
        run_one("m10_neg513", 16'hFDFF, 2'b10, 16'h00FF);
        run_one("m00_neg513", 16'hFDFF, 2'b00, 16'hFDFF);
        run_one("m11_neg513", 16'hFDFF, 2'b11, 16'hFDFF);
        run_one("m01_zero", 16'h0000, 2'b01, E_0000);
        run_one("m01_r256", 16'hFFFF, 2'b01, E_FFFF);
        run_one("m01_d257", 16'hFEFF, 2'b01, E_FEFF);
        run_one("m10_10000", 16'h2710, 2'b10, 16'h0010);

        // Backpressure: out_ready low for the first 4 cycles of a 5-product stream.
        ni = 0;
        no = 0;
        for (int cyc = 0; cyc < 40 && no < 5; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 4);
            in_valid  = (ni < 5);
            if (ni < 5) in_product = sp[ni];
            in_mode = 2'b01;
            #1;
            if (cyc == 1) begin
                check_b("bp_ready_one_accept", in_ready, 1'b1);
            end
            if (cyc == 2 || cyc == 3) begin
                check_b("bp_ready_full", in_ready, 1'b0);
                check_b("bp_hold_valid", out_valid, 1'b1);
                check_w("bp_hold_result", out_result, se[0]);
            end
            if (out_valid && out_ready) begin
                check_w("bp_out_result", out_result, se[no]);
                check_w("bp_out_mode", 16'(out_mode), 16'h0001);
                no++;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) ni++;
        end
        in_valid = 1'b0;
        check_w("bp_result_count", 16'(no), 16'd5);

        // Reset while both stages hold data and the output is stalled.
        @(negedge clk);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_product = 16'h2710;
        in_mode    = 2'b01;
        @(posedge clk);
        @(negedge clk);
        in_product = 16'h4000;
        @(posedge clk);
        @(negedge clk);
        check_b("mid_valid_before_rst", out_valid, 1'b1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_b("mid_rst_out_valid", out_valid, 1'b0);
        check_w("mid_rst_out_result", out_result, 16'h0000);
        check_b("mid_rst_in_ready", in_ready, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_b("mid_rst_no_emit", out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
